// File: rtl/mips_pkg.sv
// Shared definitions for the memory port arbiter: FSM encoding, error data and the
// registered memory command layout.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FETCH = 2'd2
    } arb_state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/wait_timer.sv
// Counts wait cycles of an outstanding memory access; expired flags the last
// allowed wait cycle so the access can be abandoned on that edge.
module wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && !expired)
            count <= count + CW'(1);
    end

    // The increment taken on this edge would make the count reach LIMIT.
    assign expired = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared memory port with fixed
// data priority, misalignment rejection and a per-access timeout.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        align_err,
    output logic        timeout_err
);
    arb_state_t state;
    mem_cmd_t   d_cmd, if_cmd;
    logic       busy, expired, d_elig, if_elig, d_aligned;

    // A requester whose ready is pulsing is finishing, not asking again.
    assign d_elig    = d_req & ~d_ready;
    assign if_elig   = if_req & ~if_ready;
    assign d_aligned = (d_addr[1:0] == 2'b00);
    assign busy      = (state != ST_IDLE);

    assign d_cmd  = '{we: d_we, addr: d_addr, wdata: d_wdata};
    assign if_cmd = '{we: 1'b0, addr: if_addr, wdata: 32'h0};

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = d_req & ~d_ready;

    wait_timer #(.LIMIT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (~busy),
        .enable  (busy & ~mem_ack),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wdata   <= 32'h0;
            if_rdata    <= 32'h0;
            d_rdata     <= 32'h0;
            if_ready    <= 1'b0;
            d_ready     <= 1'b0;
            align_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            align_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (d_elig && !d_aligned) begin
                        d_ready   <= 1'b1;
                        align_err <= 1'b1;
                    end else if (d_elig) begin
                        state     <= ST_DATA;
                        mem_req   <= 1'b1;
                        mem_we    <= d_cmd.we;
                        mem_addr  <= d_cmd.addr;
                        mem_wdata <= d_cmd.wdata;
                    end else if (if_elig) begin
                        state     <= ST_FETCH;
                        mem_req   <= 1'b1;
                        mem_we    <= if_cmd.we;
                        mem_addr  <= if_cmd.addr;
                        mem_wdata <= if_cmd.wdata;
                    end
                end
                ST_DATA: begin
                    if (mem_ack || expired) begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        d_ready <= 1'b1;
                        // Stores never disturb the load data register.
                        if (!mem_we)
                            d_rdata <= mem_ack ? mem_rdata : ERR_DATA;
                        if (!mem_ack)
                            timeout_err <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (mem_ack || expired) begin
                        state    <= ST_IDLE;
                        mem_req  <= 1'b0;
                        if_ready <= 1'b1;
                        if_rdata <= mem_ack ? mem_rdata : ERR_DATA;
                        if (!mem_ack)
                            timeout_err <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected read data is queued per port when a
// request is issued and popped by a monitor when the matching ready pulses.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic        stall_if;
    logic        stall_mem;
    logic        align_err;
    logic        timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] if_q[$];
    logic [31:0] d_q[$];

    mem_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .align_err(align_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every ready pulse must match a queued expectation.
    always @(negedge clk) begin
        if (if_ready === 1'b1 || d_ready === 1'b1)
            chk("ready_overlap", {31'b0, if_ready & d_ready}, 32'd0);
        if (if_ready === 1'b1) begin
            if (if_q.size() == 0) chk("if_ready_unexpected", {31'b0, if_ready}, 32'd0);
            else chk("if_rdata", if_rdata, if_q.pop_front());
        end
        if (d_ready === 1'b1) begin
            if (d_q.size() == 0) chk("d_ready_unexpected", {31'b0, d_ready}, 32'd0);
            else chk("d_rdata", d_rdata, d_q.pop_front());
        end
    end

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Single fetch, ack one cycle after mem_req
        if_req = 1'b1; if_addr = 32'h0;
        if_q.push_back(32'h2010_0005);
        tick();
        chk("f1_mem_req", {31'b0, mem_req}, 32'd1);
        chk("f1_mem_we", {31'b0, mem_we}, 32'd0);
        chk("f1_mem_addr", mem_addr, 32'h0);
        chk("f1_stall_if", {31'b0, stall_if}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h2010_0005;
        tick();
        chk("f1_mem_req_drop", {31'b0, mem_req}, 32'd0);
        chk("f1_if_ready", {31'b0, if_ready}, 32'd1);
        chk("f1_stall_if_done", {31'b0, stall_if}, 32'd0);
        if_req = 1'b0; mem_ack = 1'b0;
        tick();
        chk("f1_if_ready_once", {31'b0, if_ready}, 32'd0);

        // Concurrent store and fetch: data first
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h54; d_wdata = 32'd7;
        if_req = 1'b1; if_addr = 32'h100;
        d_q.push_back(32'h0);
        if_q.push_back(32'h1111_1111);
        tick();
        chk("s_mem_we", {31'b0, mem_we}, 32'd1);
        chk("s_mem_addr", mem_addr, 32'h54);
        chk("s_mem_wdata", mem_wdata, 32'd7);
        chk("s_stall_if", {31'b0, stall_if}, 32'd1);
        chk("s_stall_mem", {31'b0, stall_mem}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
        tick();
        chk("s_d_ready", {31'b0, d_ready}, 32'd1);
        chk("s_stall_if_hold", {31'b0, stall_if}, 32'd1);
        d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
        tick();
        chk("s_f_mem_addr", mem_addr, 32'h100);
        chk("s_f_mem_we", {31'b0, mem_we}, 32'd0);
        chk("s_f_mem_wdata", mem_wdata, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        chk("s_f_if_ready", {31'b0, if_ready}, 32'd1);
        if_req = 1'b0; mem_ack = 1'b0;
        tick();

        // Load with ack after 5 wait cycles
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50;
        d_q.push_back(32'hAB);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("ld_mem_req", {31'b0, mem_req}, 32'd1);
            chk("ld_mem_addr", mem_addr, 32'h50);
            chk("ld_mem_we", {31'b0, mem_we}, 32'd0);
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 32'hAB;
        tick();
        chk("ld_d_ready", {31'b0, d_ready}, 32'd1);
        chk("ld_mem_req_drop", {31'b0, mem_req}, 32'd0);
        d_req = 1'b0; mem_ack = 1'b0;
        tick();

        // Misaligned data access with a fetch pending, then fetch timeout
        d_req = 1'b1; d_addr = 32'h53;
        if_req = 1'b1; if_addr = 32'h200;
        d_q.push_back(32'hAB);
        if_q.push_back(32'hDEAD_BEEF);
        tick();
        chk("mis_align_err", {31'b0, align_err}, 32'd1);
        chk("mis_d_ready", {31'b0, d_ready}, 32'd1);
        chk("mis_no_mem_req", {31'b0, mem_req}, 32'd0);
        d_req = 1'b0;
        tick();
        chk("mis_align_once", {31'b0, align_err}, 32'd0);
        chk("to_mem_req", {31'b0, mem_req}, 32'd1);
        chk("to_mem_addr", mem_addr, 32'h200);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("to_wait_req", {31'b0, mem_req}, 32'd1);
            chk("to_wait_err", {31'b0, timeout_err}, 32'd0);
        end
        tick();
        chk("to_mem_req_drop", {31'b0, mem_req}, 32'd0);
        chk("to_if_ready", {31'b0, if_ready}, 32'd1);
        chk("to_err_set", {31'b0, timeout_err}, 32'd1);
        if_req = 1'b0;
        tick();
        tick();
        chk("to_err_sticky", {31'b0, timeout_err}, 32'd1);

        // Reset during a data wait, then a late ack
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
        tick();
        chk("rd_mem_req", {31'b0, mem_req}, 32'd1);
        tick();
        reset_n = 1'b0;
        #1;
        chk("rd_mem_req_rst", {31'b0, mem_req}, 32'd0);
        chk("rd_mem_addr_rst", mem_addr, 32'h0);
        chk("rd_d_rdata_rst", d_rdata, 32'h0);
        chk("rd_if_rdata_rst", if_rdata, 32'h0);
        chk("rd_timeout_rst", {31'b0, timeout_err}, 32'd0);
        d_req = 1'b0;
        tick();
        reset_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h55;
        tick();
        tick();
        chk("rd_late_ack_req", {31'b0, mem_req}, 32'd0);
        chk("rd_late_ack_d_rdata", d_rdata, 32'h0);
        mem_ack = 1'b0;
        tick();

        // Ack coincident with the timeout edge counts as a normal ack
        if_req = 1'b1; if_addr = 32'h300;
        if_q.push_back(32'h77);
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("co_mem_req", {31'b0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h77;
        tick();
        chk("co_if_ready", {31'b0, if_ready}, 32'd1);
        chk("co_no_timeout", {31'b0, timeout_err}, 32'd0);
        if_req = 1'b0; mem_ack = 1'b0;
        tick();
        tick();

        chk("if_q_drained", if_q.size(), 32'd0);
        chk("d_q_drained", d_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
